// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and constants for the synchronous FIFO and its read-side
// stream adapter (fifo_pop_stream).
//   FIFO_DWIDTH_DEFAULT : default data word width shared by FIFO and adapter
//   occ_t               : 0..2 word count of the adapter's output buffer
//   occ_pending()       : buffered words plus the word still in flight
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DWIDTH_DEFAULT = 8;

  typedef logic [1:0] occ_t;

  // Words already owned by the adapter: the ones sitting in the buffer plus
  // the one whose pop was issued last cycle and arrives on fifo_dout now.
  // The pop rule keeps this at or below 2, so it fits in occ_t.
  function automatic occ_t occ_pending(input occ_t occ, input logic inflight);
    return occ + occ_t'(inflight);
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_pop_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_pop_stream_if
// Bundles the FIFO read side and the downstream valid/ready stream of the
// fifo_pop_stream adapter.
//   fifo_empty  : FIFO empty flag                  (into adapter)
//   fifo_dout   : FIFO read data, valid after pop  (into adapter)
//   fifo_rd_en  : pop request to the FIFO          (from adapter, combinational)
//   flush       : discard buffered/in-flight words (into adapter)
//   out_valid   : out_data holds a word            (from adapter)
//   out_ready   : consumer accepts the word        (into adapter)
//   out_data    : head word                        (from adapter)
//   level       : buffered word count 0..2         (from adapter)
// master = adapter side, slave = FIFO plus consumer side.
// -----------------------------------------------------------------------------
interface fifo_pop_stream_if #(
  parameter int DWIDTH = fifo_pkg::FIFO_DWIDTH_DEFAULT
);
  import fifo_pkg::*;

  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  occ_t              level;

  modport master (
    input  fifo_empty, fifo_dout, flush, out_ready,
    output fifo_rd_en, out_valid, out_data, level
  );

  modport slave (
    output fifo_empty, fifo_dout, flush, out_ready,
    input  fifo_rd_en, out_valid, out_data, level
  );

endinterface : fifo_pop_stream_if

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
// Synchronous FIFO with a registered read port: a pop (rd_en && !empty) at a
// rising edge loads dout, which then holds until the next pop. Writes to a
// full FIFO are ignored.
//   clk, rst : clock, synchronous active-high reset
//   wr_en    : write request
//   din      : write data
//   rd_en    : pop request
//   dout     : read data, valid the cycle after a pop
//   full     : no room for a write
//   empty    : nothing to pop
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DWIDTH = FIFO_DWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] din,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              do_wr, do_rd;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
    count_d = count_q + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count already make
  // stale contents unreachable, and leaving it unreset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout = dout_q;

endmodule : fifo

// File: rtl/skid_buf2.sv
// -----------------------------------------------------------------------------
// skid_buf2
// Two-entry ordered register buffer. e0 is the head; on pop, e1 moves up to
// e0, and a push lands in the first slot left free after that shift, so a
// push and a pop in the same cycle keep FIFO order.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop all entries (count -> 0), wins over push
//   push       : write push_data into the buffer
//   push_data  : word to store
//   pop        : remove the head word
//   count      : number of stored words, 0..2
//   head       : current head word (e0)
// The caller never pushes into a full buffer without popping in that cycle,
// and never pops an empty buffer.
// -----------------------------------------------------------------------------
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DWIDTH = FIFO_DWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output occ_t              count,
  output logic [DWIDTH-1:0] head
);

  occ_t              count_q, count_d;
  occ_t              kept;
  logic [DWIDTH-1:0] e0_q, e0_d;
  logic [DWIDTH-1:0] e1_q, e1_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    e0_d    = e0_q;
    e1_d    = e1_q;
    kept    = count_q - occ_t'(pop);

    if (pop) begin
      e0_d = e1_q;
    end

    // First free slot after this cycle's shift.
    if (push) begin
      if (kept == 2'd0) begin
        e0_d = push_data;
      end else begin
        e1_d = push_data;
      end
    end

    count_d = kept + occ_t'(push);
    if (clear) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples its _d value from before the edge.
    if (rst) begin
      count_q <= '0;
      // The entries are cleared too: the head is visible on out_data and
      // must read zero out of reset.
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign count = count_q;
  assign head  = e0_q;

endmodule : skid_buf2

// File: rtl/fifo_pop_stream.sv
// -----------------------------------------------------------------------------
// fifo_pop_stream
// Read-side adapter for the synchronous FIFO. Issues pops, captures fifo_dout
// the cycle after each pop into a 2-entry buffer (skid_buf2) and presents the
// head as a valid/ready stream. Two buffer slots plus one pop in flight give
// one word per cycle despite the FIFO's registered read latency.
//   clk              : clock, rising edge
//   rst              : synchronous reset, active-high
//   bus (master)     : fifo_empty/fifo_dout/fifo_rd_en to the FIFO,
//                      out_valid/out_ready/out_data/level to the consumer,
//                      flush to discard buffered and in-flight words
// The only combinational input-to-output path is into fifo_rd_en.
// -----------------------------------------------------------------------------
module fifo_pop_stream
  import fifo_pkg::*;
#(
  parameter int DWIDTH = FIFO_DWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  fifo_pop_stream_if.master bus
);

  occ_t              occ;
  logic [DWIDTH-1:0] head;
  logic              inflight_q, inflight_d;
  logic              out_valid;
  logic              hs;
  logic              drop;
  logic              capture;
  logic              rd_en;

  always_comb begin
    out_valid = (occ != 2'd0);
    hs        = out_valid && bus.out_ready;
    // Flush suppresses the pop of its own cycle, so the only in-flight word a
    // flush can meet is the one arriving on fifo_dout in that same cycle.
    drop      = bus.flush && inflight_q;
    capture   = inflight_q && !drop;
    // A slot is free if fewer than two words are owned, or if the head
    // leaves this cycle; the latter keeps streaming at one word per cycle.
    rd_en     = !rst && !bus.flush && !bus.fifo_empty &&
                ((occ_pending(occ, inflight_q) < 2'd2) || hs);
    inflight_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  skid_buf2 #(
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.flush),
    .push      (capture),
    .push_data (bus.fifo_dout),
    .pop       (hs),
    .count     (occ),
    .head      (head)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = head;
  assign bus.level      = occ;

endmodule : fifo_pop_stream
